// File: rtl/popcount_4.sv
// popcount_4: registered population counter built from 4-bit group lookups and a balanced adder tree.
// Define POPCOUNT4_SAT_EN to saturate ovec on overflow; by default the count wraps modulo 2^CWIDTH.
module popcount_4 #(
    parameter int VWIDTH = 8,
    parameter int CWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VWIDTH-1:0] ivec,
    input  logic              ivalid,
    output logic [CWIDTH-1:0] ovec,
    output logic              ovalid
);

    localparam int NGROUPS = (VWIDTH + 3) / 4;
    localparam int LEVELS  = $clog2(NGROUPS);
    localparam int NLEAVES = 1 << LEVELS;
    localparam int SUMW    = $clog2(VWIDTH + 1);
    // Tree nodes must hold a full group count (0..4) even for tiny vectors.
    localparam int TREEW   = (SUMW < 3) ? 3 : SUMW;

    logic [NGROUPS*4-1:0] w_padded;
    logic [SUMW-1:0]      w_full;
    logic [CWIDTH-1:0]    w_reduced;
    logic [CWIDTH-1:0]    r_ovec;
    logic                 r_ovalid;

    function automatic logic [2:0] groupCount(input logic [3:0] nib);
        logic [2:0] cnt;
        case (nib)
            4'h0:                      cnt = 3'd0;
            4'h1, 4'h2, 4'h4, 4'h8:    cnt = 3'd1;
            4'h3, 4'h5, 4'h6,
            4'h9, 4'hA, 4'hC:          cnt = 3'd2;
            4'h7, 4'hB, 4'hD, 4'hE:    cnt = 3'd3;
            default:                   cnt = 3'd4;
        endcase
        return cnt;
    endfunction

    always_comb begin
        w_padded             = '0;
        w_padded[VWIDTH-1:0] = ivec;
    end

    // Level 0 holds the group counts (zero-filled up to a power of two); each level above halves the node count.
    for (genvar lvl = 0; lvl <= LEVELS; lvl++) begin : g_lvl
        localparam int NODES = NLEAVES >> lvl;
        logic [TREEW-1:0] w_sum [NODES];
        if (lvl == 0) begin : g_leaf
            for (genvar n = 0; n < NODES; n++) begin : g_node
                if (n < NGROUPS) begin : g_grp
                    assign w_sum[n] = TREEW'(groupCount(w_padded[4*n +: 4]));
                end else begin : g_pad
                    assign w_sum[n] = '0;
                end
            end
        end else begin : g_add
            for (genvar n = 0; n < NODES; n++) begin : g_node
                assign w_sum[n] = g_lvl[lvl-1].w_sum[2*n] + g_lvl[lvl-1].w_sum[2*n+1];
            end
        end
    end

    assign w_full = g_lvl[LEVELS].w_sum[0][SUMW-1:0];

    if (CWIDTH >= SUMW) begin : g_fits
        assign w_reduced = CWIDTH'(w_full);
    end else begin : g_narrow
`ifdef POPCOUNT4_SAT_EN
        assign w_reduced = (|w_full[SUMW-1:CWIDTH]) ? '1 : w_full[CWIDTH-1:0];
`else
        assign w_reduced = w_full[CWIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovec   <= '0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovec   <= w_reduced;
            r_ovalid <= ivalid;
        end
    end

    assign ovec   = r_ovec;
    assign ovalid = r_ovalid;

endmodule

// File: tb/tb_popcount_4.sv
// Testbench for popcount_4: directed vectors on VWIDTH=8/9/10/11/16 instances (CWIDTH=4) plus a random stream.
// Overflow expectations follow POPCOUNT4_SAT_EN when it is defined for the build.
module tb_popcount_4;

    logic        clk;
    logic        rst_n;
    logic        ivalid;
    logic [7:0]  vec8;
    logic [8:0]  vec9;
    logic [9:0]  vec10;
    logic [10:0] vec11;
    logic [15:0] vec16;
    logic [3:0]  out8, out9, out10, out11, out16;
    logic        val8, val9, val10, val11, val16;

    int checkCount = 0;
    int errorCount = 0;

`ifdef POPCOUNT4_SAT_EN
    localparam int OVF16 = 15;
`else
    localparam int OVF16 = 0;
`endif

    popcount_4 #(.VWIDTH(8),  .CWIDTH(4)) dut8  (.clk(clk), .rst_n(rst_n), .ivec(vec8),  .ivalid(ivalid), .ovec(out8),  .ovalid(val8));
    popcount_4 #(.VWIDTH(9),  .CWIDTH(4)) dut9  (.clk(clk), .rst_n(rst_n), .ivec(vec9),  .ivalid(ivalid), .ovec(out9),  .ovalid(val9));
    popcount_4 #(.VWIDTH(10), .CWIDTH(4)) dut10 (.clk(clk), .rst_n(rst_n), .ivec(vec10), .ivalid(ivalid), .ovec(out10), .ovalid(val10));
    popcount_4 #(.VWIDTH(11), .CWIDTH(4)) dut11 (.clk(clk), .rst_n(rst_n), .ivec(vec11), .ivalid(ivalid), .ovec(out11), .ovalid(val11));
    popcount_4 #(.VWIDTH(16), .CWIDTH(4)) dut16 (.clk(clk), .rst_n(rst_n), .ivec(vec16), .ivalid(ivalid), .ovec(out16), .ovalid(val16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int e8, input int e9, input int e10,
                            input int e11, input int e16, input int eValid);
        checkOutput({tag, "/w8"},  int'(out8),  e8);
        checkOutput({tag, "/w9"},  int'(out9),  e9);
        checkOutput({tag, "/w10"}, int'(out10), e10);
        checkOutput({tag, "/w11"}, int'(out11), e11);
        checkOutput({tag, "/w16"}, int'(out16), e16);
        checkOutput({tag, "/valid8"},  int'(val8),  eValid);
        checkOutput({tag, "/valid16"}, int'(val16), eValid);
    endtask

    task automatic applyStimulus(input logic [7:0] v8, input logic [8:0] v9, input logic [9:0] v10,
                                 input logic [10:0] v11, input logic [15:0] v16, input logic vld);
        vec8   = v8;
        vec9   = v9;
        vec10  = v10;
        vec11  = v11;
        vec16  = v16;
        ivalid = vld;
        @(posedge clk);
        #1;
    endtask

    function automatic int refCount(input logic [15:0] v, input int width);
        int cnt = 0;
        for (int i = 0; i < width; i++) cnt += int'(v[i]);
        if (cnt > 15) begin
`ifdef POPCOUNT4_SAT_EN
            cnt = 15;
`else
            cnt = cnt % 16;
`endif
        end
        return cnt;
    endfunction

    initial begin
        logic [15:0] r;
        logic        rv;

        rst_n  = 1'b0;
        ivalid = 1'b1;
        vec8   = 8'hFF;
        vec9   = 9'h1FF;
        vec10  = 10'h3FF;
        vec11  = 11'h7FF;
        vec16  = 16'hFFFF;
        #3;
        checkAll("reset_noclk", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h00, 9'h000, 10'h000, 11'h000, 16'h0000, 1'b1);
        checkAll("zero", 0, 0, 0, 0, 0, 1);

        applyStimulus(8'h01, 9'h001, 10'h001, 11'h001, 16'h0001, 1'b1);
        checkAll("bit0", 1, 1, 1, 1, 1, 1);
        applyStimulus(8'h02, 9'h002, 10'h002, 11'h002, 16'h0002, 1'b1);
        checkAll("bit1", 1, 1, 1, 1, 1, 1);
        applyStimulus(8'h80, 9'h100, 10'h200, 11'h400, 16'h8000, 1'b0);
        checkAll("msb", 1, 1, 1, 1, 1, 0);

        applyStimulus(8'hFF, 9'h1FF, 10'h3FF, 11'h7FF, 16'hFFFF, 1'b1);
        checkAll("all_ones", 8, 9, 10, 11, OVF16, 1);
        applyStimulus(8'hFE, 9'h1FE, 10'h3FE, 11'h7FE, 16'hFFFE, 1'b1);
        checkAll("ones_but_bit0", 7, 8, 9, 10, 15, 1);

        applyStimulus(8'b01010101, 9'b010101010, 10'b0101010101, 11'b01010101010, 16'h5555, 1'b1);
        checkAll("alternating", 4, 4, 5, 5, 8, 1);

        // Random stream: each result must reflect the vector sampled on the preceding edge.
        for (int i = 0; i < 24; i++) begin
            r  = 16'($urandom);
            rv = 1'($urandom_range(0, 1));
            applyStimulus(r[7:0], r[8:0], r[9:0], r[10:0], r, rv);
            checkAll($sformatf("stream%0d", i), refCount(r, 8), refCount(r, 9), refCount(r, 10),
                     refCount(r, 11), refCount(r, 16), int'(rv));
        end

        applyStimulus(8'hFF, 9'h1FF, 10'h3FF, 11'h7FF, 16'hFFFF, 1'b1);
        checkAll("pre_midreset", 8, 9, 10, 11, OVF16, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("midreset_async", 0, 0, 0, 0, 0, 0);
        applyStimulus(8'h0F, 9'h00F, 10'h00F, 11'h00F, 16'h000F, 1'b1);
        checkAll("midreset_held", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'hFE, 9'h1FE, 10'h3FE, 11'h7FE, 16'hFFFE, 1'b1);
        checkAll("after_release", 7, 8, 9, 10, 15, 1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
